mdu_hilo: RTL
=============

Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage, directly upstream of the data-memory/writeback stage; its MFHI/MFLO output is muxed into Result.
- Handles MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Asserts Stall to freeze the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- DIV0_LO, all-ones, LO value written on divide-by-zero.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- Ins  input  32  current instruction; op=Ins[31:26], funct=Ins[5:0].
- En  input  1  instruction valid/advancing this cycle.
- Rdata1  input  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO source).
- Rdata2  input  WIDTH  rt value (multiplier/divisor).
- MdResult  output  WIDTH  HI for MFHI, LO for MFLO, else 0; combinational.
- Stall  output  1  pipeline must hold the current instruction; combinational.
- Busy  output  1  iteration in progress; registered.
- Done  output  1  one-cycle pulse after HI/LO are updated by mul/div.
- HI, LO  output  WIDTH  architectural registers.

Behaviour:
- Decode is valid only when op==0 (R-type) and En=1. Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
- Reset: state=IDLE; HI, LO, Busy, Done and internal accumulators all 0. RST overrides everything, including an operation mid-iteration; a partial result is discarded and HI/LO are cleared.
- States:
  - IDLE: on a valid mul/div, latch operand magnitudes (absolute values for signed ops; raw values for unsigned), record the result signs, clear the counter, go to MUL or DIV, Busy=1.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, then FIX.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then FIX.
  - FIX: apply sign correction, write HI/LO, Busy=0, go to DONE.
  - DONE: Done=1 for one cycle, return to IDLE. A new op may be accepted in DONE, with the same rules as IDLE.
- Latency:
  - The accept edge is edge 0.
  - HI/LO are written on edge WIDTH+1 (33 for the default width).
  - Busy is high from after edge 0 until edge WIDTH+1.
- Signed results:
  - MULT: the 2*WIDTH product is negated if the operand signs differ; HI is the upper half, LO the lower half.
  - DIV: the quotient (LO) is negated if the signs differ; the remainder (HI) takes the dividend's sign.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (DIV or DIVU): HI=Rdata1 as latched, LO=DIV0_LO. It still takes the full latency.
- MTHI/MTLO: write only when not Busy, taking effect on the next edge. A same-cycle MFHI/MFLO is not possible because there is one instruction per cycle.
- Stall = Busy AND valid decode of any of the eight functs above. While Stall is high the instruction is not accepted and has no side effects. Non-MDU instructions never stall.
- MdResult reflects the current HI/LO; it is valid only when Stall=0.
- When Busy and En=0, or for an unrelated instruction, iteration continues undisturbed.

Optional Feature:
- FAST_MULT_EN defined:
  - MULT/MULTU compute the full product in one cycle with a single-cycle multiplier.
  - Accept edge 0; HI/LO are written on edge 1; Busy high for exactly one cycle (IDLE→FIX→DONE path); Done pulses after edge 1.
  - DIV/DIVU are unchanged.
- FAST_MULT_EN undefined: all ops are iterative as described in Behaviour; no hardware multiplier is inferred.

Test Plan:
- MULTU with Rdata1=0xFFFFFFFF, Rdata2=0xFFFFFFFF → after 33 edges HI=0xFFFFFFFE, LO=0x00000001, Done pulses once, Busy high for 33 cycles. With FAST_MULT_EN: same values after 1 edge.
- MULT -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 ÷ 2 → LO=3, HI=1.
- DIVU 0x1234 ÷ 0 → HI=0x00001234, LO=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- MFLO presented on cycle 5 of a DIV → Stall=1 until the HI/LO write edge, then Stall=0 and MdResult equals the new LO. An ADD presented during Busy → Stall=0.
- MTHI 0xCAFEBABE, then MFHI → MdResult=0xCAFEBABE. MTLO while Busy → stalled, LO unchanged until the op completes.
- RST asserted on iteration 10 of a MULT → next edge: Busy=0, HI=LO=0, Done never pulses. A following MULTU 2×3 gives LO=6, HI=0.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo : iterative multiply/divide unit with architectural HI/LO.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   Ins, En         instruction word and its valid/advance strobe
//   Rdata1, Rdata2  rs / rt operands
//   MdResult        HI on MFHI, LO on MFLO, otherwise 0 (combinational)
//   Stall           hold the pipeline: busy and an MDU instruction is present
//   Busy, Done      iteration in progress / one-cycle completion pulse
//   HI, LO          architectural result registers
//
// Build option: define FAST_MULT_EN for a single-cycle MULT/MULTU
// (IDLE -> FIX -> DONE); division stays iterative either way.
//
// state | meaning
// IDLE  | waiting for a mul/div; MTHI/MTLO are written here
// MUL   | shift-add, one multiplier bit per cycle
// DIV   | restoring division, one quotient bit per cycle
// FIX   | sign correction and HI/LO write
// DONE  | Done pulse; accepts a new op exactly like IDLE
module mdu_hilo #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [31:0]      Ins,
   input  logic             En,
   input  logic [WIDTH-1:0] Rdata1,
   input  logic [WIDTH-1:0] Rdata2,
   output logic [WIDTH-1:0] MdResult,
   output logic             Stall,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t             r_state, w_next;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_a, r_raw1, r_hi, r_lo;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_div, r_neg_q, r_neg_r, r_div0, r_busy, r_done;

   logic [5:0]         w_funct;
   logic               w_rtype, w_mfhi, w_mthi, w_mflo, w_mtlo, w_mul, w_div;
   logic               w_signed, w_accept, w_unused;
   logic [WIDTH-1:0]   w_mag1, w_mag2;
   logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_rem_diff;
   logic [2*WIDTH-1:0] w_mul_step, w_div_step, w_prod_fix;
   logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

   assign w_unused = ^Ins[25:6];

   assign w_rtype  = En && (Ins[31:26] == 6'd0);
   assign w_funct  = Ins[5:0];
   assign w_mfhi   = w_rtype && (w_funct == 6'h10);
   assign w_mthi   = w_rtype && (w_funct == 6'h11);
   assign w_mflo   = w_rtype && (w_funct == 6'h12);
   assign w_mtlo   = w_rtype && (w_funct == 6'h13);
   assign w_mul    = w_rtype && ((w_funct == 6'h18) || (w_funct == 6'h19));
   assign w_div    = w_rtype && ((w_funct == 6'h1A) || (w_funct == 6'h1B));
   // MULT/DIV have funct[0]=0, the unsigned forms funct[0]=1
   assign w_signed = ~w_funct[0];

   assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && (w_mul || w_div);

   assign w_mag1 = (w_signed && Rdata1[WIDTH-1]) ? -Rdata1 : Rdata1;
   assign w_mag2 = (w_signed && Rdata2[WIDTH-1]) ? -Rdata2 : Rdata2;

   // Multiply: acc = {partial product, remaining multiplier bits}
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
   assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide: acc = {remainder, dividend bits shifting into quotient bits}.
   // Bit WIDTH of the difference is the borrow: set means "restore".
   assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_rem_diff = w_rem_sh - {1'b0, r_a};
   assign w_div_step = w_rem_diff[WIDTH] ?
                       {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0} :
                       {w_rem_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   assign w_prod_fix = r_neg_q ? -r_acc : r_acc;

   always_comb begin
      w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod_fix[WIDTH-1:0];
      if (r_is_div) begin
         if (r_div0) begin
            w_fix_hi = r_raw1;
            w_fix_lo = DIV0_LO;
         end else begin
            w_fix_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            w_fix_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
         end
      end
   end

`ifdef FAST_MULT_EN
   logic [2*WIDTH-1:0] w_fast_prod;
   assign w_fast_prod = {{WIDTH{1'b0}}, w_mag1} * {{WIDTH{1'b0}}, w_mag2};
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (r_state == S_DONE) w_next = S_IDLE;
            if (w_accept) begin
`ifdef FAST_MULT_EN
               w_next = w_div ? S_DIV : S_FIX;
`else
               w_next = w_div ? S_DIV : S_MUL;
`endif
            end
         end
         S_MUL, S_DIV: if (r_cnt == CNT_LAST) w_next = S_FIX;
         S_FIX:        w_next = S_DONE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_acc    <= '0;
         r_a      <= '0;
         r_raw1   <= '0;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_busy   <= 1'b1;
                  r_cnt    <= '0;
                  r_is_div <= w_div;
                  r_raw1   <= Rdata1;
                  r_div0   <= (Rdata2 == '0);
                  r_neg_q  <= w_signed && (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
                  r_neg_r  <= w_signed && Rdata1[WIDTH-1];
                  r_a      <= w_div ? w_mag2 : w_mag1;
`ifdef FAST_MULT_EN
                  r_acc    <= w_div ? {{WIDTH{1'b0}}, w_mag1} : w_fast_prod;
`else
                  r_acc    <= {{WIDTH{1'b0}}, w_div ? w_mag1 : w_mag2};
`endif
               end else begin
                  if (w_mthi) r_hi <= Rdata1;
                  if (w_mtlo) r_lo <= Rdata1;
               end
            end
            S_MUL: begin
               r_acc <= w_mul_step;
               r_cnt <= r_cnt + 1'b1;
            end
            S_DIV: begin
               r_acc <= w_div_step;
               r_cnt <= r_cnt + 1'b1;
            end
            S_FIX: begin
               r_hi   <= w_fix_hi;
               r_lo   <= w_fix_lo;
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign HI    = r_hi;
   assign LO    = r_lo;
   assign Busy  = r_busy;
   assign Done  = r_done;
   assign Stall = r_busy && (w_mfhi || w_mthi || w_mflo || w_mtlo || w_mul || w_div);

   always_comb begin
      MdResult = '0;
      if (w_mfhi)      MdResult = r_hi;
      else if (w_mflo) MdResult = r_lo;
   end
endmodule
